// File: rtl/telem_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : telem_rx
//  Function : 8N1 UART byte receiver plus telemetry frame parser that recovers
//             12-bit battery, current and torque readings from the TX stream.
//  Revision : 1.0 - initial release
// ============================================================================
module telem_rx #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] torque,
   output logic        vld,
   output logic        frm_err
);

   localparam logic [11:0] c_half_bit = 12'(BAUD_DIV / 2);
   localparam logic [11:0] c_full_bit = 12'(BAUD_DIV);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [2:0] {
      P_HUNT_AA = 3'd0,
      P_HUNT_55 = 3'd1,
      P_B2      = 3'd2,
      P_B3      = 3'd3,
      P_B4      = 3'd4,
      P_B5      = 3'd5,
      P_B6      = 3'd6,
      P_B7      = 3'd7
   } prs_state_t;

   rx_state_t   r_rx_state;
   rx_state_t   w_rx_next;
   prs_state_t  r_prs_state;
   prs_state_t  w_prs_next;

   logic        r_rx_meta;
   logic        r_rx_sync;
   logic        r_rx_prev;
   logic [11:0] r_baud_cnt;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic        r_byte_rdy;

   logic [11:0] r_sh_batt;
   logic [11:0] r_sh_curr;
   logic [3:0]  r_sh_torque_hi;

   logic        w_tick;
   logic        w_fall;
   logic        w_load_half;
   logic        w_load_full;
   logic        w_shift_en;
   logic        w_byte_done;
   logic        w_stop_err;
   logic        w_p_vld;
   logic        w_p_err;

   assign w_tick = (r_baud_cnt == 12'd1);
   assign w_fall = r_rx_prev & ~r_rx_sync;

   // Synchronizer and edge-detect history idle at the line's mark level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= RX;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state <= RX_IDLE;
      end else begin
         r_rx_state <= w_rx_next;
      end
   end

   always_comb begin
      w_rx_next   = r_rx_state;
      w_load_half = 1'b0;
      w_load_full = 1'b0;
      w_shift_en  = 1'b0;
      w_byte_done = 1'b0;
      w_stop_err  = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            if (w_fall) begin
               w_rx_next   = RX_START;
               w_load_half = 1'b1;
            end
         end
         RX_START: begin
            if (w_tick) begin
               if (r_rx_sync) begin
                  w_rx_next = RX_IDLE;
               end else begin
                  w_rx_next   = RX_DATA;
                  w_load_full = 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (w_tick) begin
               w_shift_en  = 1'b1;
               w_load_full = 1'b1;
               if (r_bit_cnt == 3'd7) begin
                  w_rx_next = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (w_tick) begin
               w_rx_next = RX_IDLE;
               if (r_rx_sync) begin
                  w_byte_done = 1'b1;
               end else begin
                  w_stop_err = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_baud_cnt <= 12'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'd0;
         r_byte_rdy <= 1'b0;
      end else begin
         if (w_load_half) begin
            r_baud_cnt <= c_half_bit;
         end else if (w_load_full) begin
            r_baud_cnt <= c_full_bit;
         end else if (r_baud_cnt != 12'd0) begin
            r_baud_cnt <= r_baud_cnt - 12'd1;
         end

         // The bit counter wraps to zero after the eighth data bit.
         if (w_load_half) begin
            r_bit_cnt <= 3'd0;
         end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end

         if (w_shift_en) begin
            r_shift <= {r_rx_sync, r_shift[7:1]};
         end

         r_byte_rdy <= w_byte_done;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prs_state <= P_HUNT_AA;
      end else begin
         r_prs_state <= w_prs_next;
      end
   end

   always_comb begin
      w_prs_next = r_prs_state;
      w_p_vld    = 1'b0;
      w_p_err    = 1'b0;
      if (w_stop_err) begin
         w_prs_next = P_HUNT_AA;
      end else if (r_byte_rdy) begin
         case (r_prs_state)
            P_HUNT_AA: begin
               if (r_shift == 8'hAA) w_prs_next = P_HUNT_55;
            end
            P_HUNT_55: begin
               if (r_shift == 8'h55) begin
                  w_prs_next = P_B2;
               end else if (r_shift != 8'hAA) begin
                  w_prs_next = P_HUNT_AA;
                  w_p_err    = 1'b1;
               end
            end
            P_B2, P_B4, P_B6: begin
               if (r_shift[7:4] != 4'd0) begin
                  w_prs_next = P_HUNT_AA;
                  w_p_err    = 1'b1;
               end else if (r_prs_state == P_B2) begin
                  w_prs_next = P_B3;
               end else if (r_prs_state == P_B4) begin
                  w_prs_next = P_B5;
               end else begin
                  w_prs_next = P_B7;
               end
            end
            P_B3: w_prs_next = P_B4;
            P_B5: w_prs_next = P_B6;
            P_B7: begin
               w_prs_next = P_HUNT_AA;
               w_p_vld    = 1'b1;
            end
         endcase
      end
   end

   // Shadow copies hold a frame in progress so an aborted frame never reaches the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_batt      <= 12'd0;
         r_sh_curr      <= 12'd0;
         r_sh_torque_hi <= 4'd0;
      end else if (r_byte_rdy) begin
         case (r_prs_state)
            P_B2:    r_sh_batt[11:8] <= r_shift[3:0];
            P_B3:    r_sh_batt[7:0]  <= r_shift;
            P_B4:    r_sh_curr[11:8] <= r_shift[3:0];
            P_B5:    r_sh_curr[7:0]  <= r_shift;
            P_B6:    r_sh_torque_hi  <= r_shift[3:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         batt    <= 12'd0;
         curr    <= 12'd0;
         torque  <= 12'd0;
         vld     <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         if (w_p_vld) begin
            batt   <= r_sh_batt;
            curr   <= r_sh_curr;
            torque <= {r_sh_torque_hi, r_shift};
         end
         vld     <= w_p_vld;
         frm_err <= w_p_err | w_stop_err;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_telem_rx.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for telem_rx: directed scenarios and randomized frames checked against
// a byte-buffer model of the telemetry frame rules.
module tb_telem_rx;

   localparam int  BAUD_DIV = 8;
   localparam real c_bit_ns = 80.0;
   localparam int  c_vld_lat = BAUD_DIV / 2 + 9 * BAUD_DIV + 4;

   typedef struct {
      bit          is_vld;
      logic [11:0] b;
      logic [11:0] c;
      logic [11:0] t;
      int          cyc;
   } evt_t;

   typedef struct {
      logic [7:0] b;
      bit         ok;
   } tx_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        RX;
   logic [11:0] batt;
   logic [11:0] curr;
   logic [11:0] torque;
   logic        vld;
   logic        frm_err;

   evt_t        obs_q[$];
   evt_t        exp_q[$];
   tx_t         tx_q[$];
   logic [7:0]  pbuf[$];
   logic [11:0] exp_batt = 12'd0;
   logic [11:0] exp_curr = 12'd0;
   logic [11:0] exp_torque = 12'd0;
   int          cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   int          collide_cnt = 0;
   int          last_start_cyc = 0;

   telem_rx #(.BAUD_DIV(BAUD_DIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .RX      (RX),
      .batt    (batt),
      .curr    (curr),
      .torque  (torque),
      .vld     (vld),
      .frm_err (frm_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vld && frm_err) collide_cnt = collide_cnt + 1;
      if (vld) obs_q.push_back('{1'b1, batt, curr, torque, cyc});
      else if (frm_err) obs_q.push_back('{1'b0, 12'h0, 12'h0, 12'h0, cyc});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Frame rules expressed over the bytes accepted since the last resync point.
   task automatic model_byte(input logic [7:0] b, input bit ok);
      if (!ok) begin
         exp_q.push_back('{1'b0, 12'h0, 12'h0, 12'h0, 0});
         pbuf.delete();
         return;
      end
      pbuf.push_back(b);
      case (pbuf.size())
         1: if (b != 8'hAA) pbuf.delete();
         2: begin
            if (b == 8'hAA) begin
               pbuf.delete();
               pbuf.push_back(8'hAA);
            end else if (b != 8'h55) begin
               exp_q.push_back('{1'b0, 12'h0, 12'h0, 12'h0, 0});
               pbuf.delete();
            end
         end
         3, 5, 7: begin
            if (b[7:4] != 4'd0) begin
               exp_q.push_back('{1'b0, 12'h0, 12'h0, 12'h0, 0});
               pbuf.delete();
            end
         end
         8: begin
            exp_batt   = {pbuf[2][3:0], pbuf[3]};
            exp_curr   = {pbuf[4][3:0], pbuf[5]};
            exp_torque = {pbuf[6][3:0], pbuf[7]};
            exp_q.push_back('{1'b1, exp_batt, exp_curr, exp_torque, 0});
            pbuf.delete();
         end
         default: ;
      endcase
   endtask

   task automatic model_reset();
      pbuf.delete();
      exp_batt   = 12'd0;
      exp_curr   = 12'd0;
      exp_torque = 12'd0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok, input real bit_ns);
      last_start_cyc = cyc;
      RX = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         #(bit_ns);
      end
      RX = ok;
      #(bit_ns);
      RX = 1'b1;
      if (!ok) #(bit_ns);
      model_byte(b, ok);
   endtask

   task automatic send_all(input real bit_ns, input int max_gap);
      while (tx_q.size() > 0) begin
         tx_t t;
         int  gap;
         t = tx_q.pop_front();
         send_byte(t.b, t.ok, bit_ns);
         gap = int'($urandom_range(max_gap, 0));
         if (gap > 0) #(bit_ns * gap);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      tx_q.push_back('{b, 1'b1});
   endtask

   task automatic push_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t,
                             input int bad_stop, input int bad_nib);
      logic [7:0] fb [8];
      fb = '{8'hAA, 8'h55, {4'h0, b[11:8]}, b[7:0], {4'h0, c[11:8]}, c[7:0],
             {4'h0, t[11:8]}, t[7:0]};
      if (bad_nib >= 0) fb[bad_nib][7:4] = 4'($urandom_range(15, 1));
      for (int i = 0; i < 8; i++) tx_q.push_back('{fb[i], (i != bad_stop)});
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic check_step(input string tag);
      int n;
      repeat (2 * BAUD_DIV) @(posedge clk);
      #1;
      chk({tag, "_evcount"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_evkind"}, 64'(obs_q[i].is_vld), 64'(exp_q[i].is_vld));
         if (exp_q[i].is_vld) begin
            chk({tag, "_evbatt"}, 64'(obs_q[i].b), 64'(exp_q[i].b));
            chk({tag, "_evcurr"}, 64'(obs_q[i].c), 64'(exp_q[i].c));
            chk({tag, "_evtorque"}, 64'(obs_q[i].t), 64'(exp_q[i].t));
         end
      end
      chk({tag, "_collide"}, 64'(collide_cnt), 64'd0);
      chk({tag, "_batt"}, 64'(batt), 64'(exp_batt));
      chk({tag, "_curr"}, 64'(curr), 64'(exp_curr));
      chk({tag, "_torque"}, 64'(torque), 64'(exp_torque));
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      RX  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_batt", 64'(batt), 64'd0);
      chk("rst_curr", 64'(curr), 64'd0);
      chk("rst_torque", 64'(torque), 64'd0);
      chk("rst_vld", 64'(vld), 64'd0);
      chk("rst_frm_err", 64'(frm_err), 64'd0);
      rst = 1'b0;
      repeat (100 * BAUD_DIV) @(posedge clk);
      check_step("idle");

      // Nominal frame with vld latency measured from the last byte's start bit.
      align();
      push_frame(12'hABC, 12'h123, 12'hFFF, -1, -1);
      send_all(c_bit_ns, 0);
      repeat (2 * BAUD_DIV) @(posedge clk);
      if (obs_q.size() > 0) chk("nominal_latency", 64'(obs_q[0].cyc - last_start_cyc), 64'(c_vld_lat));
      check_step("nominal");

      align();
      push_byte(8'h13);
      push_byte(8'hAA);
      push_frame(12'h001, 12'h002, 12'h003, -1, -1);
      send_all(c_bit_ns, 0);
      check_step("resync");

      align();
      push_frame(12'h456, 12'h789, 12'h0AB, 4, -1);
      send_all(c_bit_ns, 0);
      check_step("bad_stop");
      align();
      push_frame(12'h5A5, 12'h0C3, 12'h7E1, -1, -1);
      send_all(c_bit_ns, 0);
      check_step("after_bad_stop");

      align();
      foreach (tx_q[i]) tx_q.delete(i);
      push_byte(8'hAA); push_byte(8'h55); push_byte(8'h1A); push_byte(8'hBC);
      push_byte(8'h01); push_byte(8'h23); push_byte(8'h0F); push_byte(8'hFF);
      send_all(c_bit_ns, 0);
      check_step("high_nibble");

      align();
      RX = 1'b0;
      #20;
      RX = 1'b1;
      repeat (4 * BAUD_DIV) @(posedge clk);
      check_step("glitch");

      // Reset lands in the middle of byte 5.
      align();
      push_frame(12'h321, 12'h654, 12'h987, -1, -1);
      for (int i = 0; i < 3; i++) void'(tx_q.pop_back());
      send_all(c_bit_ns, 0);
      RX = 1'b0;
      #(c_bit_ns * 3);
      rst = 1'b1;
      RX  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_step("mid_reset");

      align();
      push_frame(12'hDEF, 12'h0F0, 12'h00F, -1, -1);
      send_all(c_bit_ns, 0);
      check_step("post_reset");

      for (int it = 0; it < 30; it++) begin
         int          kind;
         logic [11:0] vb;
         logic [11:0] vc;
         logic [11:0] vt;
         kind = int'($urandom_range(4, 0));
         vb   = 12'($urandom_range(4095, 0));
         vc   = 12'($urandom_range(4095, 0));
         vt   = 12'($urandom_range(4095, 0));
         align();
         case (kind)
            0: push_frame(vb, vc, vt, -1, -1);
            1: push_frame(vb, vc, vt, -1, -1);
            2: push_frame(vb, vc, vt, int'($urandom_range(7, 0)), -1);
            3: push_frame(vb, vc, vt, -1, 2 * int'($urandom_range(3, 1)));
            default: begin
               for (int j = 0; j < int'($urandom_range(4, 1)); j++) push_byte(8'($urandom_range(255, 0)));
               push_frame(vb, vc, vt, -1, -1);
            end
         endcase
         send_all((kind == 1) ? c_bit_ns * 1.02 : c_bit_ns, (kind == 0) ? 2 : 0);
         check_step("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
